// File: rtl/maskbus_reg_pkg.sv
// maskbus_reg shared definitions: display mode encoding.
// Imported by the top level; no ports.
package maskbus_reg_pkg;

    // LED display rules selected by the synchronised mode input
    typedef enum logic [1:0] {
        MODE_XOR    = 2'b00,
        MODE_BLINK  = 2'b01,
        MODE_SHOW   = 2'b10,
        MODE_FREEZE = 2'b11
    } mode_e;

endpackage

// File: rtl/maskbus_reg_debounce.sv
// debounce: 1-bit 2-FF synchroniser followed by a counter debouncer.
// Ports: clk, reset (sync, active-high), raw (async in), db (debounced out).
module debounce #(
    parameter int DEBOUNCE = 16
) (
    input  logic clk,
    input  logic reset,
    input  logic raw,
    output logic db
);

    localparam int CW = $clog2(DEBOUNCE);

    logic          meta;
    logic          sync;
    logic [CW-1:0] cnt;

    always_ff @(posedge clk) begin
        if (reset) begin
            meta <= 1'b0;
            sync <= 1'b0;
            db   <= 1'b0;
            cnt  <= '0;
        end else begin
            meta <= raw;
            sync <= meta;
            // Any agreement restarts the window, so only an
            // uninterrupted run of DEBOUNCE disagreeing cycles is accepted.
            if (sync == db) begin
                cnt <= '0;
            end else if (cnt == CW'(DEBOUNCE - 1)) begin
                db  <= sync;
                cnt <= '0;
            end else begin
                cnt <= cnt + CW'(1);
            end
        end
    end

endmodule

// File: rtl/maskbus_reg.sv
// maskbus_reg: debounced switch bank, loadable mask and LED display modes.
// Ports: i_clk, i_reset (sync, active-high), i_sw, i_load, i_mode -> o_led, o_mask.
module maskbus_reg
    import maskbus_reg_pkg::*;
#(
    parameter int              WIDTH      = 4,
    parameter logic [WIDTH-1:0] RESET_MASK = 4'b1010,
    parameter int              DEBOUNCE   = 16,
    parameter int              BLINK_HALF = 6_000_000
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic [WIDTH-1:0] i_sw,
    input  logic             i_load,
    input  logic [1:0]       i_mode,
    output logic [WIDTH-1:0] o_led,
    output logic [WIDTH-1:0] o_mask
);

    localparam int PW = (BLINK_HALF > 1) ? $clog2(BLINK_HALF) : 1;

    // Switches occupy the low bits, the load button the top bit.
    logic [WIDTH:0]   raw_bus;
    logic [WIDTH:0]   db_bus;
    logic [WIDTH-1:0] sw_db;
    logic             load_db;

    assign raw_bus = {i_load, i_sw};

    for (genvar g = 0; g <= WIDTH; g++) begin : g_db
        debounce #(
            .DEBOUNCE(DEBOUNCE)
        ) u_db (
            .clk  (i_clk),
            .reset(i_reset),
            .raw  (raw_bus[g]),
            .db   (db_bus[g])
        );
    end

    assign sw_db   = db_bus[WIDTH-1:0];
    assign load_db = db_bus[WIDTH];

    // Mode is quasi-static, so it is synchronised but not debounced.
    logic [1:0] mode_meta;
    mode_e      mode_sync;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            mode_meta <= 2'b00;
            mode_sync <= MODE_XOR;
        end else begin
            mode_meta <= i_mode;
            mode_sync <= mode_e'(mode_meta);
        end
    end

    // Blink prescaler: phase flips every BLINK_HALF cycles.
    logic [PW-1:0] pre_cnt;
    logic          phase;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            pre_cnt <= '0;
            phase   <= 1'b0;
        end else if (pre_cnt == PW'(BLINK_HALF - 1)) begin
            pre_cnt <= '0;
            phase   <= ~phase;
        end else begin
            pre_cnt <= pre_cnt + PW'(1);
        end
    end

    // Mask register with rising-edge load; holding the button
    // keeps load_prev high so no repeat capture happens.
    logic [WIDTH-1:0] mask;
    logic             load_prev;
    logic             load_rise;

    assign load_rise = load_db & ~load_prev;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            mask      <= RESET_MASK;
            load_prev <= 1'b0;
        end else begin
            load_prev <= load_db;
            if (load_rise) begin
                mask <= sw_db;
            end
        end
    end

    assign o_mask = mask;

    // Output mux, registered; freeze simply keeps the last value.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            o_led <= '0;
        end else begin
            unique case (mode_sync)
                MODE_XOR:    o_led <= sw_db ^ mask;
                MODE_BLINK:  o_led <= sw_db ^ (mask & {WIDTH{phase}});
                MODE_SHOW:   o_led <= mask;
                MODE_FREEZE: o_led <= o_led;
            endcase
        end
    end

endmodule
